// File: rtl/lfo_pkg.sv
// lfo_pkg: shared types and constants for the multi-channel LFO.
//   lfo_mode_t  - per-channel waveform select (triangle, saw, square, hold)
//   div_state_t - states of the shared round-robin step divider
//   LFO_*_DEFAULT - default waveform bounds
//   idx_width() - width of a channel index (at least 1 bit)
`timescale 1ns/1ps
package lfo_pkg;

    typedef enum logic [1:0] {
        LFO_TRI  = 2'd0,
        LFO_SAW  = 2'd1,
        LFO_SQR  = 2'd2,
        LFO_HOLD = 2'd3
    } lfo_mode_t;

    typedef enum logic [1:0] {
        DIV_LOAD  = 2'd0,
        DIV_RUN   = 2'd1,
        DIV_WRITE = 2'd2
    } div_state_t;

    localparam int LFO_MIN_DEFAULT = 16384;
    localparam int LFO_MAX_DEFAULT = 32768;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfo_step_div.sv
// lfo_step_div: sequential restoring divider, one quotient bit per cycle.
//   clk, rst      - clock, asynchronous active-low reset
//   start         - load dividend/divisor and begin a division
//   dividend      - numerator (snapshotted on start)
//   divisor       - denominator (snapshotted on start); 0 yields quotient 0
//   done          - high for one cycle once the quotient is complete,
//                   LEN_W cycles after the start cycle
//   quotient      - result, stable from done until the next start
`timescale 1ns/1ps
module lfo_step_div #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] dividend,
    input  logic [LEN_W-1:0] divisor,
    output logic             done,
    output logic [LEN_W-1:0] quotient
);

    localparam int CNT_W = $clog2(LEN_W + 1);

    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] quo;
    logic [LEN_W-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [LEN_W:0]   shifted;
    logic [LEN_W:0]   trial;

    // Dividend bits are shifted out of quo from the top while quotient
    // bits are shifted in at the bottom, so one register serves both.
    assign shifted = {rem, quo[LEN_W-1]};
    assign trial   = shifted - {1'b0, dsr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= '0;
                quo  <= dividend;
                dsr  <= divisor;
                cnt  <= CNT_W'(LEN_W);
                busy <= 1'b1;
            end else if (busy) begin
                if (shifted >= {1'b0, dsr}) begin
                    rem <= trial[LEN_W-1:0];
                    quo <= {quo[LEN_W-2:0], 1'b1};
                end else begin
                    rem <= shifted[LEN_W-1:0];
                    quo <= {quo[LEN_W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // A zero divisor makes every trial subtraction succeed (all-ones
    // quotient); report 0 so a zero period freezes the channel.
    assign quotient = (dsr == '0) ? '0 : quo;

endmodule

// File: rtl/lfo_multi.sv
// lfo_multi: multi-channel bounded LFO (triangle / rising saw / square).
//   clk, rst    - clock, asynchronous active-low reset
//   clk_en      - tick strobe; waveforms advance only on ticks
//   period      - per-channel half-period in ticks (0 = frozen)
//   mode        - per-channel lfo_mode_t (3 = frozen)
//   sync        - per-channel restart to MIN_VALUE, rising
//   out         - per-channel registered waveform value
//   dir         - per-channel direction, 1 = rising
//   wrap        - one-cycle pulse on reversal at MAX or saw wrap
//   step_valid  - sticky, set once the channel's first step is written
// A single divider computes step = RANGE / period for each channel in turn
// (LEN_W+2 cycles per channel), so every channel's step refreshes with a
// fixed latency of CHANNELS*(LEN_W+2) cycles. LEN_W must be >= WIDTH.
`timescale 1ns/1ps
module lfo_multi
    import lfo_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 16,
    parameter int LEN_W     = 32,
    parameter int MIN_VALUE = LFO_MIN_DEFAULT,
    parameter int MAX_VALUE = LFO_MAX_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic [CHANNELS-1:0][LEN_W-1:0] period,
    input  logic [CHANNELS-1:0][1:0]       mode,
    input  logic [CHANNELS-1:0]            sync,
    output logic [CHANNELS-1:0][WIDTH-1:0] out,
    output logic [CHANNELS-1:0]            dir,
    output logic [CHANNELS-1:0]            wrap,
    output logic [CHANNELS-1:0]            step_valid
);

    localparam int RANGE = MAX_VALUE - MIN_VALUE;
    localparam int IDX_W = idx_width(CHANNELS);
    localparam int CNT_W = $clog2(LEN_W + 1);

    localparam logic [WIDTH-1:0]        MIN_W   = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0]        MAX_W   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0]        RANGE_W = WIDTH'(RANGE);
    localparam logic [LEN_W-1:0]        RANGE_L = LEN_W'(RANGE);
    localparam logic signed [WIDTH+1:0] MIN_S   = (WIDTH+2)'(MIN_VALUE);
    localparam logic signed [WIDTH+1:0] MAX_S   = (WIDTH+2)'(MAX_VALUE);

    // ---------------- shared divider scheduler ----------------
    div_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] run_cnt;
    logic             div_start;
    logic             div_done;
    logic [LEN_W-1:0] div_q;
    logic [WIDTH-1:0] step_new;

    assign div_start = (state == DIV_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_LOAD;
            idx     <= '0;
            run_cnt <= '0;
        end else begin
            case (state)
                DIV_LOAD: begin
                    state   <= DIV_RUN;
                    run_cnt <= '0;
                end
                DIV_RUN: begin
                    run_cnt <= run_cnt + CNT_W'(1);
                    if (run_cnt == CNT_W'(LEN_W - 1))
                        state <= DIV_WRITE;
                end
                DIV_WRITE: begin
                    state <= DIV_LOAD;
                    idx   <= (idx == IDX_W'(CHANNELS - 1)) ? '0 : idx + IDX_W'(1);
                end
                default: state <= DIV_LOAD;
            endcase
        end
    end

    lfo_step_div #(.LEN_W(LEN_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (RANGE_L),
        .divisor  (period[idx]),
        .done     (div_done),
        .quotient (div_q)
    );

    // A period of 1 would otherwise give step = RANGE exactly; anything
    // larger (impossible today, but cheap to guard) clamps to RANGE.
    assign step_new = (div_q > RANGE_L) ? RANGE_W : div_q[WIDTH-1:0];

    // ---------------- per-channel phase engines ----------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]        step_q;
        logic [WIDTH-1:0]        phase_q;
        logic [WIDTH-1:0]        phase_nx;
        logic [WIDTH-1:0]        out_q;
        logic [WIDTH-1:0]        out_nx;
        logic                    dir_q;
        logic                    dir_nx;
        logic                    wrap_q;
        logic                    wrap_nx;
        logic                    sv_q;
        logic                    step_wr;
        logic                    advance;
        logic signed [WIDTH+1:0] n;
        lfo_mode_t               md;

        assign md      = lfo_mode_t'(mode[c]);
        assign step_wr = (state == DIV_WRITE) && div_done && (idx == IDX_W'(c));
        assign advance = clk_en && sv_q && (step_q != '0) && (md != LFO_HOLD);

        // Saw always climbs, even if the channel was falling when the mode
        // switched, so it continues upward from the current phase.
        assign n = (dir_q || md == LFO_SAW)
                 ? $signed({2'b00, phase_q}) + $signed({2'b00, step_q})
                 : $signed({2'b00, phase_q}) - $signed({2'b00, step_q});

        always_comb begin
            phase_nx = phase_q;
            dir_nx   = dir_q;
            wrap_nx  = 1'b0;
            if (sync[c]) begin
                phase_nx = MIN_W;
                dir_nx   = 1'b1;
            end else if (advance) begin
                if (md == LFO_SAW) begin
                    dir_nx = 1'b1;
                    if (n >= MAX_S) begin
                        phase_nx = MIN_W;
                        wrap_nx  = 1'b1;
                    end else begin
                        phase_nx = n[WIDTH-1:0];
                    end
                end else if (n >= MAX_S) begin
                    // Clamp and reverse on the same tick.
                    phase_nx = MAX_W;
                    dir_nx   = 1'b0;
                    wrap_nx  = 1'b1;
                end else if (n <= MIN_S) begin
                    phase_nx = MIN_W;
                    dir_nx   = 1'b1;
                end else begin
                    phase_nx = n[WIDTH-1:0];
                end
            end
            out_nx = (md == LFO_SQR) ? (dir_nx ? MAX_W : MIN_W) : phase_nx;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                step_q  <= '0;
                sv_q    <= 1'b0;
                phase_q <= MIN_W;
                dir_q   <= 1'b1;
                wrap_q  <= 1'b0;
                out_q   <= MIN_W;
            end else begin
                phase_q <= phase_nx;
                dir_q   <= dir_nx;
                wrap_q  <= wrap_nx;
                out_q   <= out_nx;
                if (step_wr) begin
                    step_q <= step_new;
                    sv_q   <= 1'b1;
                end
            end
        end

        assign out[c]        = out_q;
        assign dir[c]        = dir_q;
        assign wrap[c]       = wrap_q;
        assign step_valid[c] = sv_q;
    end

endmodule

// File: tb/tb_lfo_multi.sv
`timescale 1ns/1ps
module tb_lfo_multi;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic [1:0][31:0] period;
    logic [1:0][1:0]  mode;
    logic [1:0]       sync;
    logic [1:0][15:0] out;
    logic [1:0]       dir;
    logic [1:0]       wrap;
    logic [1:0]       step_valid;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    lfo_multi #(
        .CHANNELS(2), .WIDTH(16), .LEN_W(32), .MIN_VALUE(16384), .MAX_VALUE(32768)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .period(period), .mode(mode),
        .sync(sync), .out(out), .dir(dir), .wrap(wrap), .step_valid(step_valid)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0; clk_en = 1'b0; period = '0; mode = '0; sync = '0;
        #12;
        checks++;
        if (out[0] !== 16'd16384) $display("FAIL reset_out0: got %0d want 16384", out[0]); else passes++;
        checks++;
        if (out[1] !== 16'd16384) $display("FAIL reset_out1: got %0d want 16384", out[1]); else passes++;
        checks++;
        if (dir !== 2'b11) $display("FAIL reset_dir: got %b want 11", dir); else passes++;
        checks++;
        if (wrap !== 2'b00) $display("FAIL reset_wrap: got %b want 00", wrap); else passes++;
        checks++;
        if (step_valid !== 2'b00) $display("FAIL reset_sv: got %b want 00", step_valid); else passes++;
    endtask

    task automatic test_first_step();
        period[0] = 32'd3;
        period[1] = 32'd4096;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        repeat (33) step_cycle();
        checks++;
        if (step_valid !== 2'b00) $display("FAIL first_sv33: got %b want 00", step_valid); else passes++;
        step_cycle();
        checks++;
        if (step_valid !== 2'b01) $display("FAIL first_sv34: got %b want 01", step_valid); else passes++;
        checks++;
        if (out[0] !== 16'd16384) $display("FAIL first_out34: got %0d want 16384", out[0]); else passes++;
    endtask

    task automatic test_triangle_ch0();
        int eo [0:7];
        bit ed [0:7];
        bit ew [0:7];
        eo = '{21845, 27306, 32767, 32768, 27307, 21846, 16385, 16384};
        ed = '{1, 1, 1, 0, 0, 0, 0, 1};
        ew = '{0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            checks++;
            if (out[0] !== 16'(eo[i]) || dir[0] !== ed[i] || wrap[0] !== ew[i])
                $display("FAIL tri0[%0d]: got out=%0d dir=%0b wrap=%0b want out=%0d dir=%0b wrap=%0b",
                         i, out[0], dir[0], wrap[0], eo[i], ed[i], ew[i]);
            else passes++;
        end
    endtask

    task automatic test_saw();
        int eo [0:7];
        bit ew [0:7];
        eo = '{21845, 27306, 32767, 16384, 21845, 27306, 32767, 16384};
        ew = '{0, 0, 0, 1, 0, 0, 0, 1};
        mode[0] = 2'd1;
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            checks++;
            if (out[0] !== 16'(eo[i]) || dir[0] !== 1'b1 || wrap[0] !== ew[i])
                $display("FAIL saw[%0d]: got out=%0d dir=%0b wrap=%0b want out=%0d dir=1 wrap=%0b",
                         i, out[0], dir[0], wrap[0], eo[i], ew[i]);
            else passes++;
        end
    endtask

    task automatic test_sync();
        int eo [0:4];
        bit ed [0:4];
        bit ew [0:4];
        eo = '{21845, 27306, 32767, 32768, 27307};
        ed = '{1, 1, 1, 0, 0};
        ew = '{0, 0, 0, 1, 0};
        mode[0] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            step_cycle();
            checks++;
            if (out[0] !== 16'(eo[i]) || dir[0] !== ed[i] || wrap[0] !== ew[i])
                $display("FAIL sync_pre[%0d]: got out=%0d dir=%0b wrap=%0b want out=%0d dir=%0b wrap=%0b",
                         i, out[0], dir[0], wrap[0], eo[i], ed[i], ew[i]);
            else passes++;
        end
        sync[0] = 1'b1;
        step_cycle();
        sync[0] = 1'b0;
        checks++;
        if (out[0] !== 16'd16384 || dir[0] !== 1'b1 || wrap[0] !== 1'b0)
            $display("FAIL sync_hit: got out=%0d dir=%0b wrap=%0b want out=16384 dir=1 wrap=0",
                     out[0], dir[0], wrap[0]);
        else passes++;
        step_cycle();
        checks++;
        if (out[0] !== 16'd21845 || dir[0] !== 1'b1)
            $display("FAIL sync_after: got out=%0d dir=%0b want out=21845 dir=1", out[0], dir[0]);
        else passes++;
    endtask

    task automatic test_hold_mode();
        mode[0] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step_cycle();
            checks++;
            if (out[0] !== 16'd21845 || dir[0] !== 1'b1)
                $display("FAIL hold[%0d]: got out=%0d dir=%0b want out=21845 dir=1", i, out[0], dir[0]);
            else passes++;
        end
    endtask

    task automatic test_triangle_ch1();
        int nwrap = 0;
        while (cyc < 67) step_cycle();
        checks++;
        if (step_valid[1] !== 1'b0) $display("FAIL tri1_sv67: got %b want 0", step_valid[1]); else passes++;
        step_cycle();
        checks++;
        if (step_valid[1] !== 1'b1 || out[1] !== 16'd16384)
            $display("FAIL tri1_sv68: got sv=%b out=%0d want sv=1 out=16384", step_valid[1], out[1]);
        else passes++;
        for (int k = 1; k <= 8192; k++) begin
            int  eo;
            bit  ed;
            bit  ew;
            bit  chk;
            step_cycle();
            if (wrap[1] === 1'b1) nwrap++;
            chk = 1'b1;
            case (k)
                1:       begin eo = 16388; ed = 1; ew = 0; end
                4095:    begin eo = 32764; ed = 1; ew = 0; end
                4096:    begin eo = 32768; ed = 0; ew = 1; end
                4097:    begin eo = 32764; ed = 0; ew = 0; end
                8191:    begin eo = 16388; ed = 0; ew = 0; end
                8192:    begin eo = 16384; ed = 1; ew = 0; end
                default: begin eo = 0; ed = 0; ew = 0; chk = 1'b0; end
            endcase
            if (chk) begin
                checks++;
                if (out[1] !== 16'(eo) || dir[1] !== ed || wrap[1] !== ew)
                    $display("FAIL tri1[k=%0d]: got out=%0d dir=%0b wrap=%0b want out=%0d dir=%0b wrap=%0b",
                             k, out[1], dir[1], wrap[1], eo, ed, ew);
                else passes++;
            end
        end
        checks++;
        if (nwrap != 1) $display("FAIL tri1_wraps: got %0d want 1", nwrap); else passes++;
    endtask

    task automatic test_square_ch1();
        mode[1] = 2'd2;
        for (int j = 1; j <= 8192; j++) begin
            int  eo;
            bit  ew;
            bit  chk;
            step_cycle();
            chk = 1'b1;
            case (j)
                1:       begin eo = 32768; ew = 0; end
                4095:    begin eo = 32768; ew = 0; end
                4096:    begin eo = 16384; ew = 1; end
                4097:    begin eo = 16384; ew = 0; end
                8192:    begin eo = 32768; ew = 0; end
                default: begin eo = 0; ew = 0; chk = 1'b0; end
            endcase
            if (chk) begin
                checks++;
                if (out[1] !== 16'(eo) || wrap[1] !== ew)
                    $display("FAIL sqr1[j=%0d]: got out=%0d wrap=%0b want out=%0d wrap=%0b",
                             j, out[1], wrap[1], eo, ew);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_div();
        while ((cyc % 68) != 10) step_cycle();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out[0] !== 16'd16384 || out[1] !== 16'd16384)
            $display("FAIL rstmid_out: got %0d/%0d want 16384/16384", out[0], out[1]);
        else passes++;
        checks++;
        if (dir !== 2'b11 || wrap !== 2'b00 || step_valid !== 2'b00)
            $display("FAIL rstmid_flags: got dir=%b wrap=%b sv=%b want 11/00/00", dir, wrap, step_valid);
        else passes++;
        period[0] = 32'd0;
        period[1] = 32'd3;
        mode      = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        repeat (33) step_cycle();
        checks++;
        if (step_valid !== 2'b00) $display("FAIL rstmid_sv33: got %b want 00", step_valid); else passes++;
        step_cycle();
        checks++;
        if (step_valid !== 2'b01) $display("FAIL rstmid_sv34: got %b want 01", step_valid); else passes++;
        while (cyc < 67) step_cycle();
        checks++;
        if (out[0] !== 16'd16384 || dir[0] !== 1'b1)
            $display("FAIL period0_frozen: got out=%0d dir=%0b want 16384/1", out[0], dir[0]);
        else passes++;
        step_cycle();
        checks++;
        if (step_valid !== 2'b11) $display("FAIL rstmid_sv68: got %b want 11", step_valid); else passes++;
        step_cycle();
        checks++;
        if (out[1] !== 16'd21845) $display("FAIL rstmid_ch1_step: got %0d want 21845", out[1]); else passes++;
        checks++;
        if (out[0] !== 16'd16384) $display("FAIL period0_still: got %0d want 16384", out[0]); else passes++;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_triangle_ch0();
        test_saw();
        test_sync();
        test_hold_mode();
        test_triangle_ch1();
        test_square_ch1();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
